// File: rtl/mcu_bus_tx_pkg.sv
// Shared definitions for the MCU bus transmitter and its receiver:
// FSM states, FIFO entry layout, command opcodes and bus widths.
package mcu_bus_tx_pkg;

    localparam int BYTE_CNT_W = 16;
    localparam int ENTRY_W    = 9;

    // Command opcodes understood by the receiver.
    localparam logic [7:0] CMD_SET_ADDRESS = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } tx_state_e;

    typedef struct packed {
        logic       is_cmd;
        logic [7:0] data;
    } tx_entry_t;

endpackage

// File: rtl/mcu_bus_tx_if.sv
// Byte-offer handshake plus parallel bus signals of mcu_bus_tx.
// master: byte producer side; slave: the transmitter itself.
interface mcu_bus_tx_if;
    import mcu_bus_tx_pkg::*;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;
    logic                  tx_is_command;
    logic                  busclk;
    logic [7:0]            bus_out;
    logic                  bus_oe;
    logic                  command_data;
    logic                  busy;
    logic [BYTE_CNT_W-1:0] byte_count;

    modport master (
        output tx_valid, tx_data, tx_is_command,
        input  tx_ready, busclk, bus_out, bus_oe,
        input  command_data, busy, byte_count
    );

    modport slave (
        input  tx_valid, tx_data, tx_is_command,
        output tx_ready, busclk, bus_out, bus_oe,
        output command_data, busy, byte_count
    );

endinterface

// File: rtl/mcu_bus_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH, sync active-high reset.
// Ports: clk_i, rst_i, push_i/wdata_i, pop_i/rdata_o (head), full, empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;
    assign rdata_o = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mcu_bus_tx.sv
// MCU parallel-bus transmitter: FIFO-buffered bytes strobed out as
// SETUP/HIGH/LOW phases of CLK_DIV cycles. Ports: sysclk, reset, io.
module mcu_bus_tx
    import mcu_bus_tx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          sysclk,
    input  logic          reset,
    mcu_bus_tx_if.slave   io
);
    tx_state_e             state_q, state_d;
    logic [7:0]            phase_q, phase_d;
    logic                  busclk_q, busclk_d;
    logic                  oe_q, oe_d;
    logic [7:0]            out_q, out_d;
    logic                  cd_q, cd_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    tx_entry_t wentry, head;
    logic      full, empty, push, pop, done;

    assign wentry = '{is_cmd: io.tx_is_command, data: io.tx_data};
    assign push   = io.tx_valid && !full;
    assign done   = (phase_q == 8'(CLK_DIV - 1));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .full    (full),
        .empty   (empty)
    );

    // Outputs are computed from the next state so they are registered
    // alongside it; bus data only changes on entry to SETUP.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 8'd1;
        busclk_d = busclk_q;
        oe_d     = oe_q;
        out_d    = out_q;
        cd_d     = cd_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                    oe_d    = 1'b1;
                    out_d   = head.data;
                    cd_d    = head.is_cmd;
                end
            end
            ST_SETUP: begin
                if (done) begin
                    state_d  = ST_HIGH;
                    phase_d  = '0;
                    busclk_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (done) begin
                    state_d  = ST_LOW;
                    phase_d  = '0;
                    busclk_d = 1'b0;
                end
            end
            ST_LOW: begin
                if (done) begin
                    phase_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_SETUP;
                        out_d   = head.data;
                        cd_d    = head.is_cmd;
                    end else begin
                        state_d = ST_IDLE;
                        oe_d    = 1'b0;
                        out_d   = '0;
                        cd_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            busclk_q <= 1'b0;
            oe_q     <= 1'b0;
            out_q    <= '0;
            cd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            busclk_q <= busclk_d;
            oe_q     <= oe_d;
            out_q    <= out_d;
            cd_q     <= cd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign io.tx_ready     = !full;
    assign io.busy         = !empty || (state_q != ST_IDLE);
    assign io.busclk       = busclk_q;
    assign io.bus_oe       = oe_q;
    assign io.bus_out      = out_q;
    assign io.command_data = cd_q;
    assign io.byte_count   = cnt_q;

endmodule

// File: tb/tb_mcu_bus_tx.sv
// Directed bench for mcu_bus_tx: CLK_DIV=4 instance for timing, burst
// and reset; CLK_DIV=1 instance for a 300-byte streaming run.
module tb_mcu_bus_tx;
    import mcu_bus_tx_pkg::*;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mcu_bus_tx_if if0 ();
    mcu_bus_tx_if if1 ();

    mcu_bus_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u0 (
        .sysclk (sysclk),
        .reset  (reset),
        .io     (if0)
    );

    mcu_bus_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) u1 (
        .sysclk (sysclk),
        .reset  (reset),
        .io     (if1)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus data must hold while busclk is high, including its rising cycle.
    logic [8:0] prev0 = '0;
    logic [8:0] prev1 = '0;
    always @(negedge sysclk) begin
        if (!reset && if0.busclk) begin
            checks++;
            assert ({if0.command_data, if0.bus_out} === prev0) else begin
                errors++;
                $error("FAIL stable0 observed=%0h expected=%0h",
                       {if0.command_data, if0.bus_out}, prev0);
            end
        end
        if (!reset && if1.busclk) begin
            checks++;
            assert ({if1.command_data, if1.bus_out} === prev1) else begin
                errors++;
                $error("FAIL stable1 observed=%0h expected=%0h",
                       {if1.command_data, if1.bus_out}, prev1);
            end
        end
        prev0 = {if0.command_data, if0.bus_out};
        prev1 = {if1.command_data, if1.bus_out};
    end

    logic [8:0] burst [5];
    logic [8:0] seen  [8];
    int         rise_cyc [8];
    int         nrise, oe_low, last, pushed, bad_data, bad_sp;
    logic       prev_bc, acc;

    initial begin
        burst[0] = {1'b1, CMD_SET_ADDRESS};
        burst[1] = 9'h0DE;
        burst[2] = 9'h0AD;
        burst[3] = 9'h0BE;
        burst[4] = 9'h0EF;
        if0.tx_valid = 1'b0; if0.tx_data = '0; if0.tx_is_command = 1'b0;
        if1.tx_valid = 1'b0; if1.tx_data = '0; if1.tx_is_command = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busclk", 32'(if0.busclk), 0);
        chk("rst_oe", 32'(if0.bus_oe), 0);
        chk("rst_out", 32'(if0.bus_out), 0);
        chk("rst_cd", 32'(if0.command_data), 0);
        chk("rst_cnt", 32'(if0.byte_count), 0);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_ready", 32'(if0.tx_ready), 1);
        reset = 1'b0;
        tick();

        // Single command byte: push at cycle 0
        if0.tx_valid = 1'b1; if0.tx_data = 8'h01; if0.tx_is_command = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        chk("c1_oe", 32'(if0.bus_oe), 0);
        chk("c1_busy", 32'(if0.busy), 1);
        tick();
        chk("c2_oe", 32'(if0.bus_oe), 1);
        chk("c2_bus", 32'({if0.command_data, if0.bus_out}), 32'h101);
        chk("c2_busclk", 32'(if0.busclk), 0);
        tick(); tick(); tick();
        chk("c5_busclk", 32'(if0.busclk), 0);
        tick();
        chk("c6_busclk", 32'(if0.busclk), 1);
        chk("c6_cnt", 32'(if0.byte_count), 1);
        tick(); tick(); tick();
        chk("c9_busclk", 32'(if0.busclk), 1);
        tick();
        chk("c10_busclk", 32'(if0.busclk), 0);
        chk("c10_oe", 32'(if0.bus_oe), 1);
        tick(); tick(); tick();
        chk("c13_oe", 32'(if0.bus_oe), 1);
        tick();
        chk("c14_oe", 32'(if0.bus_oe), 0);
        chk("c14_busy", 32'(if0.busy), 0);
        tick();

        // Burst of five into a depth-4 FIFO
        pushed = 0;
        for (int c = 0; c < 40 && pushed < 5; c++) begin
            if0.tx_valid      = 1'b1;
            if0.tx_is_command = burst[pushed][8];
            if0.tx_data       = burst[pushed][7:0];
            acc = if0.tx_ready;
            tick();
            if (acc) pushed++;
        end
        chk("burst_pushed", 32'(pushed), 5);
        chk("burst_full", 32'(if0.tx_ready), 0);
        // A sixth byte offered while full must be refused.
        if0.tx_is_command = 1'b0; if0.tx_data = 8'h55;
        nrise = 0; oe_low = 0; prev_bc = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if0.tx_valid = 1'b0;
            if (nrise >= 1 && nrise < 5 && !if0.bus_oe) oe_low++;
            if (if0.busclk && !prev_bc) begin
                if (nrise < 8) begin
                    seen[nrise]     = {if0.command_data, if0.bus_out};
                    rise_cyc[nrise] = c;
                end
                nrise++;
            end
            prev_bc = if0.busclk;
        end
        chk("burst_nrise", 32'(nrise), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("burst_byte%0d", k), 32'(seen[k]), 32'(burst[k]));
        end
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("burst_gap%0d", k),
                32'(rise_cyc[k] - rise_cyc[k-1]), 12);
        end
        chk("burst_oe_low", 32'(oe_low), 0);
        chk("burst_cnt", 32'(if0.byte_count), 6);
        chk("burst_busy", 32'(if0.busy), 0);

        // Reset during HIGH of the second byte, with a same-cycle push
        pushed = 0;
        for (int c = 0; c < 10 && pushed < 3; c++) begin
            if0.tx_valid = 1'b1; if0.tx_is_command = 1'b0;
            if0.tx_data  = 8'(8'h11 * (pushed + 1));
            acc = if0.tx_ready;
            tick();
            if (acc) pushed++;
        end
        if0.tx_valid = 1'b0;
        nrise = 0; prev_bc = if0.busclk;
        for (int c = 0; c < 100 && nrise < 2; c++) begin
            tick();
            if (if0.busclk && !prev_bc) nrise++;
            prev_bc = if0.busclk;
        end
        chk("rst_find", 32'(nrise), 2);
        reset = 1'b1;
        if0.tx_valid = 1'b1; if0.tx_data = 8'h77;
        tick();
        reset = 1'b0;
        if0.tx_valid = 1'b0;
        chk("mid_busclk", 32'(if0.busclk), 0);
        chk("mid_oe", 32'(if0.bus_oe), 0);
        chk("mid_cnt", 32'(if0.byte_count), 0);
        chk("mid_busy", 32'(if0.busy), 0);
        chk("mid_ready", 32'(if0.tx_ready), 1);
        nrise = 0; prev_bc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (if0.busclk && !prev_bc) nrise++;
            prev_bc = if0.busclk;
        end
        chk("mid_nostrobe", 32'(nrise), 0);
        chk("mid_cnt_end", 32'(if0.byte_count), 0);

        // CLK_DIV=1 streaming of 300 bytes
        pushed = 0; nrise = 0; last = 0; bad_data = 0; bad_sp = 0;
        prev_bc = 1'b0;
        for (int c = 0; c < 3000 && nrise < 300; c++) begin
            if1.tx_valid      = (pushed < 300);
            if1.tx_data       = pushed[7:0];
            if1.tx_is_command = pushed[0];
            acc = if1.tx_valid && if1.tx_ready;
            tick();
            if (acc) pushed++;
            if (if1.busclk && !prev_bc) begin
                last = (nrise == 0) ? c - 3 : last;
                if ({if1.command_data, if1.bus_out} !==
                    {nrise[0], nrise[7:0]}) bad_data++;
                if (c - last != 3) bad_sp++;
                last = c;
                nrise++;
            end
            prev_bc = if1.busclk;
        end
        if1.tx_valid = 1'b0;
        chk("div1_nrise", 32'(nrise), 300);
        chk("div1_data", 32'(bad_data), 0);
        chk("div1_gap", 32'(bad_sp), 0);
        chk("div1_cnt", 32'(if1.byte_count), 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
